// File: rtl/transmit_dac.sv
// SPI-style 16-bit frame transmitter for a 12-bit DAC: cs/sclk/sdata with a done tick.
// Optional two's-complement to offset-binary conversion via TRANSMIT_DAC_OFFSET_BIN_EN.
module transmit_dac #(
  parameter int DATA_W  = 12,
  parameter int FRAME_W = 16,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        pd,
  output logic              tx_busy,
  output logic              tx_done_tick,
  output logic              cs,
  output logic              sclk_out,
  output logic              sdata
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(FRAME_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_QUIET = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [BW-1:0]      bit_cnt;
  logic [FRAME_W-1:0] shreg;
  logic               quiet_ph;
  logic               tick;
  logic [DATA_W-1:0]  din_adj;
  logic [FRAME_W-1:0] frame_word;

`ifdef TRANSMIT_DAC_OFFSET_BIN_EN
  // Flipping the sign bit maps two's-complement zero to mid-scale.
  assign din_adj = din ^ (DATA_W'(1) << (DATA_W - 1));
`else
  assign din_adj = din;
`endif

  always_comb begin
    frame_word               = '0;
    frame_word[DATA_W+1:0]   = {pd, din_adj};
  end

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      quiet_ph     <= 1'b0;
      cs           <= 1'b1;
      sclk_out     <= 1'b1;
      sdata        <= 1'b0;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        S_IDLE: begin
          cs       <= 1'b1;
          sclk_out <= 1'b1;
          sdata    <= 1'b0;
          cnt      <= '0;
          bit_cnt  <= '0;
          quiet_ph <= 1'b0;
          if (tx_start) begin
            shreg   <= frame_word;
            sdata   <= frame_word[FRAME_W-1];
            cs      <= 1'b0;
            tx_busy <= 1'b1;
            state   <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          cnt <= tick ? '0 : cnt + CW'(1);
          if (tick) begin
            if (sclk_out) begin
              // Falling edge: the DAC samples the bit already on sdata.
              sclk_out <= 1'b0;
              bit_cnt  <= bit_cnt + BW'(1);
            end else if (bit_cnt == BIT_LAST) begin
              sclk_out     <= 1'b1;
              sdata        <= 1'b0;
              cs           <= 1'b1;
              tx_done_tick <= 1'b1;
              shreg        <= '0;
              cnt          <= '0;
              state        <= S_QUIET;
            end else begin
              sclk_out <= 1'b1;
              shreg    <= shreg << 1;
              sdata    <= shreg[FRAME_W-2];
            end
          end
        end

        S_QUIET: begin
          // Two divider periods of SYNC-high before the next frame may start.
          cnt <= tick ? '0 : cnt + CW'(1);
          if (tick) begin
            quiet_ph <= ~quiet_ph;
            if (quiet_ph) begin
              tx_busy <= 1'b0;
              state   <= S_IDLE;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
